ibex_multdiv_iter: RTL and testbench

//  Iterative 32-bit multiplier/divider (RV32M MUL/MULH*/DIV*/REM*) built as the

---
 rtl/ibex_pkg.sv | 27 ++
 rtl/ibex_multdiv_iter.sv | 190 +++++++++++++++++++
 tb/tb_ibex_multdiv_iter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/ibex_pkg.sv
// Shared types for the iterative multiply/divide unit.
// Operation and FSM encodings live here so the EX stage and the unit agree.
package ibex_pkg;

    // RV32M operation classes handled by the multdiv unit
    typedef enum logic [1:0] {
        MD_OP_MULL = 2'd0,
        MD_OP_MULH = 2'd1,
        MD_OP_DIV  = 2'd2,
        MD_OP_REM  = 2'd3
    } md_op_e;

    // Sequencer states, walked strictly in declaration order for a full operation
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ABS_A  = 3'd1,
        ABS_B  = 3'd2,
        COMP   = 3'd3,
        NEG_LO = 3'd4,
        NEG_HI = 3'd5,
        FINISH = 3'd6
    } md_state_e;

    // Iteration counter start value: one COMP cycle per operand bit
    localparam logic [4:0] MD_LAST_ITER = 5'd31;

endpackage

// File: rtl/ibex_multdiv_iter.sv
// Iterative 32-bit RV32M multiplier/divider. It owns no adder: every add,
// subtract and negate is issued to the ALU shared adder through the 33-bit
// operand ports ({X,1} and {Y,cin}) and the result returns on alu_adder_ext_i.
// Signed operations run on magnitudes, then the low and high result words are
// conditionally negated, giving a fixed 37-cycle latency.
module ibex_multdiv_iter
    import ibex_pkg::*;
#(
    parameter int DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 mult_en_i,
    input  logic                 div_en_i,
    input  logic [1:0]           operator_i,
    input  logic [1:0]           signed_mode_i,
    input  logic [DataWidth-1:0] op_a_i,
    input  logic [DataWidth-1:0] op_b_i,
    input  logic [DataWidth+1:0] alu_adder_ext_i,
    output logic [DataWidth:0]   alu_operand_a_o,
    output logic [DataWidth:0]   alu_operand_b_o,
    output logic                 multdiv_sel_o,
    output logic                 valid_o,
    output logic [DataWidth-1:0] multdiv_result_o
);

    md_state_e            r_state;
    md_op_e               r_operator;
    logic [4:0]           r_counter;
    logic [DataWidth-1:0] r_opA;      // multiplicand, or dividend shifting out MSB-first
    logic [DataWidth-1:0] r_opB;      // multiplier shifting out LSB-first, or divisor
    logic [DataWidth-1:0] r_accHi;    // product high word, or partial remainder
    logic [DataWidth-1:0] r_accLo;    // product low word, or quotient
    logic                 r_signA;
    logic                 r_signB;
    logic                 r_divZero;
    logic                 r_carry;    // carry out of the low-word negation

    md_state_e            w_nextState;
    logic                 w_en;
    logic                 w_isMul;
    logic [DataWidth-1:0] w_sum;
    logic                 w_carryOut;
    logic [DataWidth-1:0] w_trial;
    logic                 w_divSuccess;
    logic                 w_negLo;
    logic                 w_negHi;
    logic                 w_unusedAdderLsb;

    assign w_en             = mult_en_i | div_en_i;
    assign w_isMul          = (r_operator == MD_OP_MULL) || (r_operator == MD_OP_MULH);
    assign w_sum            = alu_adder_ext_i[DataWidth:1];
    assign w_carryOut       = alu_adder_ext_i[DataWidth+1];
    assign w_unusedAdderLsb = alu_adder_ext_i[0];
    assign w_trial          = {r_accHi[DataWidth-2:0], r_opA[DataWidth-1]};
    assign w_divSuccess     = r_accHi[DataWidth-1] | w_carryOut;
    assign w_negLo          = w_isMul ? (r_signA ^ r_signB) : ((r_signA ^ r_signB) & ~r_divZero);
    assign w_negHi          = w_isMul ? (r_signA ^ r_signB) : r_signA;

    // Next-state selection and the adder operands requested in each state
    always_comb begin
        w_nextState     = r_state;
        alu_operand_a_o = '0;
        alu_operand_b_o = '0;
        multdiv_sel_o   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_en) w_nextState = ABS_A;
            end
            ABS_A: begin
                multdiv_sel_o   = 1'b1;
                alu_operand_a_o = {{DataWidth{1'b0}}, 1'b1};
                alu_operand_b_o = r_signA ? {~r_opA, 1'b1} : {r_opA, 1'b0};
                w_nextState     = ABS_B;
            end
            ABS_B: begin
                multdiv_sel_o   = 1'b1;
                alu_operand_a_o = {{DataWidth{1'b0}}, 1'b1};
                alu_operand_b_o = r_signB ? {~r_opB, 1'b1} : {r_opB, 1'b0};
                w_nextState     = COMP;
            end
            COMP: begin
                multdiv_sel_o = 1'b1;
                if (w_isMul) begin
                    alu_operand_a_o = {r_accHi, 1'b1};
                    alu_operand_b_o = {(r_opB[0] ? r_opA : {DataWidth{1'b0}}), 1'b0};
                end else begin
                    alu_operand_a_o = {w_trial, 1'b1};
                    alu_operand_b_o = {~r_opB, 1'b1};
                end
                if (r_counter == 5'd0) w_nextState = NEG_LO;
            end
            NEG_LO: begin
                multdiv_sel_o   = 1'b1;
                alu_operand_a_o = {{DataWidth{1'b0}}, 1'b1};
                alu_operand_b_o = w_negLo ? {~r_accLo, 1'b1} : {r_accLo, 1'b0};
                w_nextState     = NEG_HI;
            end
            NEG_HI: begin
                multdiv_sel_o   = 1'b1;
                alu_operand_a_o = {{DataWidth{1'b0}}, 1'b1};
                if (w_isMul) begin
                    alu_operand_b_o = w_negHi ? {~r_accHi, r_carry} : {r_accHi, 1'b0};
                end else begin
                    alu_operand_b_o = w_negHi ? {~r_accHi, 1'b1} : {r_accHi, 1'b0};
                end
                w_nextState = FINISH;
            end
            FINISH: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
        if ((r_state != IDLE) && !w_en) w_nextState = IDLE;
    end

    // Result strobe and word selection: MULL/DIV read the low word, MULH/REM the high word
    always_comb begin
        valid_o          = 1'b0;
        multdiv_result_o = '0;
        if (r_state == FINISH) begin
            valid_o          = 1'b1;
            multdiv_result_o = r_operator[0] ? r_accHi : r_accLo;
        end
    end

    // State register plus the datapath registers, each updated from the adder result
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_operator <= MD_OP_MULL;
            r_counter  <= '0;
            r_opA      <= '0;
            r_opB      <= '0;
            r_accHi    <= '0;
            r_accLo    <= '0;
            r_signA    <= 1'b0;
            r_signB    <= 1'b0;
            r_divZero  <= 1'b0;
            r_carry    <= 1'b0;
        end else begin
            r_state <= w_nextState;
            case (r_state)
                IDLE: begin
                    if (w_en) begin
                        r_operator <= md_op_e'(operator_i);
                        r_opA      <= op_a_i;
                        r_opB      <= op_b_i;
                        r_signA    <= signed_mode_i[0] & op_a_i[DataWidth-1];
                        r_signB    <= signed_mode_i[1] & op_b_i[DataWidth-1];
                        r_divZero  <= (op_b_i == '0);
                        r_accHi    <= '0;
                        r_accLo    <= '0;
                        r_carry    <= 1'b0;
                    end
                end
                ABS_A: begin
                    r_opA <= w_sum;
                end
                ABS_B: begin
                    r_opB     <= w_sum;
                    r_counter <= MD_LAST_ITER;
                end
                COMP: begin
                    if (r_counter != 5'd0) r_counter <= r_counter - 5'd1;
                    if (w_isMul) begin
                        {r_accHi, r_accLo} <= {w_carryOut, w_sum, r_accLo[DataWidth-1:1]};
                        r_opB              <= {1'b0, r_opB[DataWidth-1:1]};
                    end else begin
                        r_accHi <= w_divSuccess ? w_sum : w_trial;
                        r_accLo <= {r_accLo[DataWidth-2:0], w_divSuccess};
                        r_opA   <= {r_opA[DataWidth-2:0], 1'b0};
                    end
                end
                NEG_LO: begin
                    r_accLo <= w_sum;
                    r_carry <= w_carryOut;
                end
                NEG_HI: begin
                    r_accHi <= w_sum;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ibex_multdiv_iter.sv
// Self-checking bench for the iterative multdiv unit. The ALU shared adder is
// modelled here as a plain addition of the two 33-bit operands; expected
// results come from 64-bit integer arithmetic on the architectural operands.
module tb_ibex_multdiv_iter;

    logic        clk;
    logic        rst;
    logic        multEn;
    logic        divEn;
    logic [1:0]  operatorIn;
    logic [1:0]  signedMode;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [33:0] aluExt;
    logic [32:0] aluOpA;
    logic [32:0] aluOpB;
    logic        sel;
    logic        valid;
    logic [31:0] result;

    int checkCount = 0;
    int errorCount = 0;

    ibex_multdiv_iter #(.DataWidth(32)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .mult_en_i        (multEn),
        .div_en_i         (divEn),
        .operator_i       (operatorIn),
        .signed_mode_i    (signedMode),
        .op_a_i           (opA),
        .op_b_i           (opB),
        .alu_adder_ext_i  (aluExt),
        .alu_operand_a_o  (aluOpA),
        .alu_operand_b_o  (aluOpB),
        .multdiv_sel_o    (sel),
        .valid_o          (valid),
        .multdiv_result_o (result)
    );

    // The ALU adder: {X,1} + {Y,cin} so that bits [32:1] hold X+Y+cin
    assign aluExt = {1'b0, aluOpA} + {1'b0, aluOpB};

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence itself ever stalls
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Architectural reference: sign/zero-extend to 64 bits and use plain arithmetic
    function automatic logic [31:0] refModel(input logic [1:0] op, input logic [1:0] mode,
                                             input logic [31:0] a, input logic [31:0] b);
        logic [63:0] av;
        logic [63:0] bv;
        logic [63:0] prod;
        longint      q;
        longint      r;
        av = mode[0] ? {{32{a[31]}}, a} : {32'h0, a};
        bv = mode[1] ? {{32{b[31]}}, b} : {32'h0, b};
        if (op < 2'd2) begin
            prod = av * bv;
            return (op == 2'd0) ? prod[31:0] : prod[63:32];
        end
        if (b == 32'h0) return (op == 2'd2) ? 32'hFFFF_FFFF : a;
        q = longint'(av) / longint'(bv);
        r = longint'(av) % longint'(bv);
        return (op == 2'd2) ? q[31:0] : r[31:0];
    endfunction

    function automatic logic [31:0] pickVal();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    // Runs one operation from its cycle 0; checks latency, select window, operand gating and result
    task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [1:0] mode,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expRes, input int expLat, input bit keepEn);
        int cyc;
        int selCycles;
        int zeroViol;
        bit seen;
        operatorIn = op;
        signedMode = mode;
        opA        = a;
        opB        = b;
        multEn     = (op < 2'd2);
        divEn      = (op >= 2'd2);
        cyc        = 0;
        selCycles  = 0;
        zeroViol   = 0;
        seen       = 1'b0;
        while (!seen && cyc < 80) begin
            @(posedge clk);
            #1;
            cyc++;
            if (sel) selCycles++;
            else if (aluOpA != 33'h0 || aluOpB != 33'h0) zeroViol++;
            if (valid) seen = 1'b1;
        end
        checkOutput({tag, "/latency"}, 64'(cyc), 64'(expLat));
        checkOutput({tag, "/selCycles"}, 64'(selCycles), 64'd36);
        checkOutput({tag, "/opGating"}, 64'(zeroViol), 64'd0);
        checkOutput({tag, "/result"}, 64'(result), 64'(expRes));
        if (!keepEn) begin
            multEn = 1'b0;
            divEn  = 1'b0;
            @(posedge clk);
            #1;
            checkOutput({tag, "/strobeOnce"}, 64'(valid), 64'd0);
        end
    endtask

    // Main sequence: reset, directed cases, abort, reset mid-op, back-to-back, random
    initial begin
        logic [1:0]  rOp;
        logic [1:0]  rMode;
        logic [31:0] rA;
        logic [31:0] rB;
        int          stray;

        rst        = 1'b1;
        multEn     = 1'b0;
        divEn      = 1'b0;
        operatorIn = 2'd0;
        signedMode = 2'd0;
        opA        = 32'h0;
        opB        = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset/valid", 64'(valid), 64'd0);
        checkOutput("reset/sel", 64'(sel), 64'd0);
        checkOutput("reset/result", 64'(result), 64'd0);
        checkOutput("reset/opA", 64'(aluOpA), 64'd0);
        checkOutput("reset/opB", 64'(aluOpB), 64'd0);
        rst = 1'b0;

        $display("[TB] directed cases");
        applyStimulus("mull_7x6", 2'd0, 2'b00, 32'd7, 32'd6, 32'h0000_002A, 37, 1'b0);
        applyStimulus("mulh_ss", 2'd1, 2'b11, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 37, 1'b0);
        applyStimulus("mull_ss", 2'd0, 2'b11, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE, 37, 1'b0);
        applyStimulus("mulh_uu", 2'd1, 2'b00, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 37, 1'b0);
        applyStimulus("div_ss", 2'd2, 2'b11, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 37, 1'b0);
        applyStimulus("rem_ss", 2'd3, 2'b11, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 37, 1'b0);
        applyStimulus("div_uu", 2'd2, 2'b00, 32'hFFFF_FFF9, 32'h2, 32'h7FFF_FFFC, 37, 1'b0);
        applyStimulus("div_uu_by0", 2'd2, 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 37, 1'b0);
        applyStimulus("rem_uu_by0", 2'd3, 2'b00, 32'd5, 32'd0, 32'h0000_0005, 37, 1'b0);
        applyStimulus("div_ss_by0", 2'd2, 2'b11, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 37, 1'b0);
        applyStimulus("rem_ss_by0", 2'd3, 2'b11, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 37, 1'b0);
        applyStimulus("div_ovf", 2'd2, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 37, 1'b0);
        applyStimulus("rem_ovf", 2'd3, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 37, 1'b0);

        $display("[TB] abort by dropping enable");
        operatorIn = 2'd0;
        signedMode = 2'b00;
        opA        = 32'd123;
        opB        = 32'd456;
        multEn     = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        multEn = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort/sel", 64'(sel), 64'd0);
        checkOutput("abort/opA", 64'(aluOpA), 64'd0);
        stray = 0;
        repeat (45) begin
            @(posedge clk);
            #1;
            if (valid) stray++;
        end
        checkOutput("abort/noValid", 64'(stray), 64'd0);

        $display("[TB] reset mid-operation");
        operatorIn = 2'd2;
        signedMode = 2'b11;
        opA        = 32'd1000;
        opB        = 32'd7;
        divEn      = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midReset/sel", 64'(sel), 64'd0);
        checkOutput("midReset/valid", 64'(valid), 64'd0);
        checkOutput("midReset/result", 64'(result), 64'd0);
        checkOutput("midReset/opB", 64'(aluOpB), 64'd0);
        rst   = 1'b0;
        divEn = 1'b0;
        stray = 0;
        repeat (45) begin
            @(posedge clk);
            #1;
            if (valid) stray++;
        end
        checkOutput("midReset/noValid", 64'(stray), 64'd0);

        $display("[TB] back-to-back");
        applyStimulus("b2b_first", 2'd1, 2'b01, 32'h8765_4321, 32'h1234_5678,
                      refModel(2'd1, 2'b01, 32'h8765_4321, 32'h1234_5678), 37, 1'b1);
        applyStimulus("b2b_second", 2'd3, 2'b11, 32'hDEAD_BEEF, 32'h0000_0013,
                      refModel(2'd3, 2'b11, 32'hDEAD_BEEF, 32'h0000_0013), 38, 1'b0);

        $display("[TB] randomized operations");
        for (int i = 0; i < 40; i++) begin
            rOp   = 2'($urandom_range(0, 3));
            rMode = 2'($urandom_range(0, 3));
            rA    = pickVal();
            rB    = pickVal();
            applyStimulus($sformatf("rand%0d_op%0d_m%0d", i, rOp, rMode), rOp, rMode, rA, rB,
                          refModel(rOp, rMode, rA, rB), 37, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
